// File: rtl/mandelbrot_core.sv
// ---------------------------------------------------------------------------
// mandelbrot_core
//
// Fixed-point escape-time engine for the fractal pipeline. A complex point c
// (signed Q4.12) is accepted on a start request, then z <= z^2 + c is iterated
// from z = 0, one iteration per clock. The result is the number of iterations
// completed before |z|^2 exceeded 4.0. If the point never escapes, the result
// is MAX_ITER with escaped low.
//
// Ports:
//   clk         in   1       system clock
//   rst         in   1       synchronous, active-high reset
//   start       in   1       request; only looked at while idle
//   c_re        in   WIDTH   real part of c, latched on accepted start
//   c_im        in   WIDTH   imaginary part of c, latched on accepted start
//   busy        out  1       high while iterating
//   done        out  1       one-cycle pulse when the result is valid
//   iter_count  out  ITER_W  iteration count of the last completed point
//   escaped     out  1       1 = escaped, 0 = iteration cap reached
// ---------------------------------------------------------------------------
module mandelbrot_core #(
   parameter int WIDTH    = 16,
   parameter int FRAC     = 12,
   parameter int ITER_W   = 6,
   parameter int MAX_ITER = 63
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  c_re,
   input  logic [WIDTH-1:0]  c_im,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter_count,
   output logic              escaped
);

   // Full-precision product width, and a wider width for sums so that
   // neither the magnitude nor the z updates can wrap before clamping.
   localparam int PW = 2 * WIDTH;
   localparam int MW = PW + 2;

   localparam logic signed [MW-1:0] ESC_LIMIT = MW'(4) << FRAC;
   localparam logic signed [MW-1:0] SAT_MAX   = MW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [MW-1:0] SAT_MIN   = ~SAT_MAX;
   localparam logic [ITER_W-1:0]    ITER_CAP  = ITER_W'(MAX_ITER);

   typedef enum logic {
      IDLE,
      ITER
   } state_t;

   state_t                   state;
   logic signed [WIDTH-1:0]  cr;
   logic signed [WIDTH-1:0]  ci;
   logic signed [WIDTH-1:0]  zr;
   logic signed [WIDTH-1:0]  zi;
   logic [ITER_W-1:0]        count;

   logic signed [PW-1:0]     ext_zr;
   logic signed [PW-1:0]     ext_zi;
   logic signed [PW-1:0]     zr2;
   logic signed [PW-1:0]     zi2;
   logic signed [PW-1:0]     zri;
   logic signed [MW-1:0]     mag;
   logic signed [MW-1:0]     next_re_wide;
   logic signed [MW-1:0]     next_im_wide;
   logic signed [WIDTH-1:0]  next_re;
   logic signed [WIDTH-1:0]  next_im;
   logic                     escape;

   // Clamp a wide intermediate back into the WIDTH-bit signed range.
   function automatic logic signed [WIDTH-1:0] sat(input logic signed [MW-1:0] v);
      logic signed [MW-1:0] clamped;
      if (v > SAT_MAX) begin
         clamped = SAT_MAX;
      end else if (v < SAT_MIN) begin
         clamped = SAT_MIN;
      end else begin
         clamped = v;
      end
      return clamped[WIDTH-1:0];
   endfunction

   // Sign-extend a product-width value to the wide sum width.
   function automatic logic signed [MW-1:0] ext_p(input logic signed [PW-1:0] v);
      return {{(MW - PW){v[PW-1]}}, v};
   endfunction

   // Sign-extend a WIDTH-bit value to the wide sum width.
   function automatic logic signed [MW-1:0] ext_w(input logic signed [WIDTH-1:0] v);
      return {{(MW - WIDTH){v[WIDTH-1]}}, v};
   endfunction

   // One iteration step. The squares and cross term are taken at full
   // precision and rescaled with arithmetic shifts; the magnitude and the
   // next z values are formed at MW bits so that nothing wraps, even when z
   // sits at the rails after saturation.
   always_comb begin
      ext_zr       = {{WIDTH{zr[WIDTH-1]}}, zr};
      ext_zi       = {{WIDTH{zi[WIDTH-1]}}, zi};
      zr2          = (ext_zr * ext_zr) >>> FRAC;
      zi2          = (ext_zi * ext_zi) >>> FRAC;
      zri          = (ext_zr * ext_zi) >>> FRAC;
      mag          = ext_p(zr2) + ext_p(zi2);
      escape       = (mag > ESC_LIMIT);
      next_re_wide = ext_p(zr2) - ext_p(zi2) + ext_w(cr);
      next_im_wide = (ext_p(zri) <<< 1) + ext_w(ci);
      next_re      = sat(next_re_wide);
      next_im      = sat(next_im_wide);
   end

   // Control FSM with registered outputs. A start while busy is simply not
   // looked at. Completion returns to IDLE in the same edge that raises done,
   // so a start held across the done cycle is accepted immediately. The
   // escape test takes priority over the cap test, and z is only advanced
   // when neither ends the point. Reset aborts any point silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         iter_count <= '0;
         escaped    <= 1'b0;
         cr         <= '0;
         ci         <= '0;
         zr         <= '0;
         zi         <= '0;
         count      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cr    <= c_re;
                  ci    <= c_im;
                  zr    <= '0;
                  zi    <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= ITER;
               end
            end
            ITER: begin
               if (escape) begin
                  iter_count <= count;
                  escaped    <= 1'b1;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else if (count == ITER_CAP) begin
                  iter_count <= ITER_CAP;
                  escaped    <= 1'b0;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  zr    <= next_re;
                  zi    <= next_im;
                  count <= count + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mandelbrot_core.sv
// ---------------------------------------------------------------------------
// tb_mandelbrot_core
//
// Directed bench for mandelbrot_core. Each launched point pushes its expected
// result onto a scoreboard queue; the entry is popped and compared when done
// pulses. Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mandelbrot_core;

   localparam int WIDTH    = 16;
   localparam int ITER_W   = 6;
   localparam int TIMEOUT  = 200;

   logic              clk;
   logic              rst;
   logic              start;
   logic [WIDTH-1:0]  c_re;
   logic [WIDTH-1:0]  c_im;
   logic              busy;
   logic              done;
   logic [ITER_W-1:0] iter_count;
   logic              escaped;

   typedef struct {
      int iter;
      int esc;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   mandelbrot_core #(
      .WIDTH    (16),
      .FRAC     (12),
      .ITER_W   (6),
      .MAX_ITER (63)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .c_re       (c_re),
      .c_im       (c_im),
      .busy       (busy),
      .done       (done),
      .iter_count (iter_count),
      .escaped    (escaped)
   );

   // 50 MHz clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Single comparison point: counts the vector, flags a miscompare.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Launch one point from a falling-edge-aligned position and record its
   // expected result. Returns one falling edge after the accepting edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im,
                                input int exp_iter, input int exp_esc);
      exp_t e;
      e.iter = exp_iter;
      e.esc  = exp_esc;
      sb.push_back(e);
      c_re  = re;
      c_im  = im;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("done_low_after_start", {31'd0, done}, 32'd0);
   endtask

   // Wait (bounded) for done, then compare against the oldest scoreboard
   // entry: result, latency in edges and busy duration. A non-negative
   // inject_at pulses a competing start that many cycles into the point.
   task automatic checkOutput(input string name, input int inject_at);
      int   cycles;
      int   busy_cycles;
      bit   seen;
      exp_t e;
      cycles      = 0;
      busy_cycles = 1;
      seen        = 1'b0;
      while (!seen && cycles < TIMEOUT) begin
         @(negedge clk);
         cycles++;
         if (inject_at >= 0 && cycles == inject_at) begin
            start = 1'b1;
            c_re  = 16'h2000;
            c_im  = 16'h0000;
         end else if (inject_at >= 0 && cycles == inject_at + 1) begin
            start = 1'b0;
         end
         if (done) begin
            seen = 1'b1;
         end else if (busy) begin
            busy_cycles++;
         end
      end
      check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({name, "_iter_count"}, {26'd0, iter_count}, e.iter);
         check({name, "_escaped"}, {31'd0, escaped}, e.esc);
         check({name, "_latency"}, cycles, e.iter + 1);
         check({name, "_busy_cycles"}, busy_cycles, e.iter + 1);
         check({name, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
      end else begin
         check({name, "_scoreboard_entry"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      int pulses;
      rst   = 1'b1;
      start = 1'b1;
      c_re  = 16'h2000;
      c_im  = 16'h0000;

      // Reset held with start asserted: everything must stay quiet.
      repeat (3) begin
         @(negedge clk);
         check("reset_busy", {31'd0, busy}, 32'd0);
         check("reset_done", {31'd0, done}, 32'd0);
         check("reset_iter_count", {26'd0, iter_count}, 32'd0);
         check("reset_escaped", {31'd0, escaped}, 32'd0);
      end
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Origin never escapes; capped at 64 cycles.
      applyStimulus(16'h0000, 16'h0000, 63, 0);
      checkOutput("origin", -1);

      // Back-to-back points launched in each done cycle.
      applyStimulus(16'h2000, 16'h0000, 2, 1);
      checkOutput("two", -1);
      applyStimulus(16'h3000, 16'h0000, 1, 1);
      checkOutput("three", -1);

      // -2.0 settles at z = 2.0 with |z|^2 exactly 4.0: no escape.
      applyStimulus(16'hE000, 16'h0000, 63, 0);
      checkOutput("minus_two", -1);

      // Extreme corner: magnitude far above 4 must not wrap.
      applyStimulus(16'h7FFF, 16'h7FFF, 1, 1);
      checkOutput("corner", -1);

      // 1+i: z1 = 1+i (|z|^2 = 2), z2 = 1+3i (|z|^2 = 10).
      applyStimulus(16'h1000, 16'h1000, 2, 1);
      checkOutput("one_plus_i", -1);

      // -4.0: z1 = -4, |z|^2 = 16.
      applyStimulus(16'hC000, 16'h0000, 1, 1);
      checkOutput("minus_four", -1);

      // 2i: z1 = 2i (|z|^2 = 4, no escape), z2 = -4+2i.
      applyStimulus(16'h0000, 16'h2000, 2, 1);
      checkOutput("two_i", -1);

      // A start pulse while busy is ignored.
      applyStimulus(16'h0000, 16'h0000, 63, 0);
      checkOutput("ignored_start", 10);

      // Abort mid-iteration with reset: no done pulse, outputs cleared.
      c_re   = 16'h0000;
      c_im   = 16'h0000;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      pulses = 0;
      repeat (19) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("abort_busy_before_reset", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done) pulses++;
         check("abort_busy", {31'd0, busy}, 32'd0);
         check("abort_iter_count", {26'd0, iter_count}, 32'd0);
         check("abort_escaped", {31'd0, escaped}, 32'd0);
      end
      check("abort_no_done", pulses, 32'd0);

      // Start on the first edge after reset release.
      rst = 1'b0;
      applyStimulus(16'h2000, 16'h0000, 2, 1);
      checkOutput("after_reset", -1);

      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("result_held", {26'd0, iter_count}, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
